// File: rtl/lo_gap_decoder_if.sv
// rtl/lo_gap_decoder_if.sv - SSP link from the gap decoder to the ARM
// Purpose: bundles the three SSP pins driven by lo_gap_decoder.
// Ports (signals):
//   ssp_clk    serial clock, ARM samples on the rising edge
//   ssp_frame  high while bit 15 (first bit) of a word is presented
//   ssp_din    serial data, MSB first
// Modports: master = decoder side (drives), slave = ARM side (samples).
interface lo_gap_decoder_if;
  logic ssp_clk;
  logic ssp_frame;
  logic ssp_din;

  modport master (output ssp_clk, output ssp_frame, output ssp_din);
  modport slave  (input  ssp_clk, input  ssp_frame, input  ssp_din);
endinterface

// File: rtl/lo_gap_decoder.sv
// rtl/lo_gap_decoder.sv - times field-on periods and reader gaps, ships them over SSP
// Purpose: synchronises and (optionally) glitch-filters the comparator field bit, counts
//   each constant-level period in pck0 cycles, queues {level, count} words and shifts them
//   out MSB first on the SSP pins.
// Build option: LO_GAP_FILTER_EN defined -> FILT_CYC-cycle glitch filter present;
//   undefined -> filtered level is the synchronised level directly.
// Ports:
//   pck0      in   sole clock
//   rst_n     in   synchronous active-low reset
//   en        in   capture enable
//   field_in  in   comparator output, 1 = field present
//   ssp       out  SSP link (ssp_clk, ssp_frame, ssp_din), master modport
//   overflow  out  sticky, a word was dropped on a full queue
//   dbg       out  filtered field level
module lo_gap_decoder #(
  parameter int CNT_W      = 15,
  parameter int FIFO_DEPTH = 4,
  parameter int FILT_CYC   = 4,
  parameter int SSP_DIV    = 8
) (
  input  logic                pck0,
  input  logic                rst_n,
  input  logic                en,
  input  logic                field_in,
  lo_gap_decoder_if.master    ssp,
  output logic                overflow,
  output logic                dbg
);

  localparam int W        = CNT_W + 1;
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int DIV_W    = $clog2(SSP_DIV);
  localparam int BIT_W    = $clog2(W);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SSP_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(W - 1);

  if (FILT_CYC < 1 || FILT_CYC > 15 || SSP_DIV < 2 || FIFO_DEPTH < 2) begin : g_param_check
    $error("lo_gap_decoder: parameter out of range");
  end

  // Two-flop synchroniser
  logic s_meta, s;
  always_ff @(posedge pck0) begin
    if (!rst_n) begin
      s_meta <= 1'b0;
      s      <= 1'b0;
    end else begin
      s_meta <= field_in;
      s      <= s_meta;
    end
  end

  logic filt;
`ifdef LO_GAP_FILTER_EN
  // filt follows s only after FILT_CYC consecutive disagreeing cycles; any
  // agreement restarts the run, so short excursions vanish entirely.
  logic [3:0] run;
  always_ff @(posedge pck0) begin
    if (!rst_n) begin
      filt <= 1'b0;
      run  <= 4'd0;
    end else if (s != filt) begin
      if (run == 4'(FILT_CYC - 1)) begin
        filt <= s;
        run  <= 4'd0;
      end else begin
        run <= run + 4'd1;
      end
    end else begin
      run <= 4'd0;
    end
  end
`else
  assign filt = s;
`endif

  assign dbg = filt;

  // Period counter. The first edge after arming only restarts the count,
  // since the start of the period that it closes was never seen.
  logic             filt_d, armed;
  logic [CNT_W-1:0] cnt;
  logic             filt_edge, push;
  logic [W-1:0]     push_word;

  assign filt_edge = (filt != filt_d);
  assign push      = en && armed && filt_edge;
  assign push_word = {filt_d, cnt};

  always_ff @(posedge pck0) begin
    if (!rst_n) begin
      filt_d <= 1'b0;
      armed  <= 1'b0;
      cnt    <= '0;
    end else begin
      filt_d <= filt;
      if (!en) begin
        cnt   <= '0;
        armed <= 1'b0;
      end else if (filt_edge) begin
        cnt   <= CNT_W'(1);
        armed <= 1'b1;
      end else if (cnt != '1) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Word queue; an extra pointer bit distinguishes full from empty.
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
  state_t state;

  logic [W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         empty, full, pop, wr_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = (state == LOAD);
  // A simultaneous pop frees the slot, so a push onto a full queue still lands.
  assign wr_en = push && (!full || pop);

  always_ff @(posedge pck0) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_word;
  end

  always_ff @(posedge pck0) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (push && !wr_en) overflow <= 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Serialiser: data is set up before each rise and changes on the fall.
  logic [W-1:0]     shreg;
  logic [DIV_W-1:0] div_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic             clk_q, frame_q, din_q;

  always_ff @(posedge pck0) begin
    if (!rst_n) begin
      state   <= IDLE;
      shreg   <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      clk_q   <= 1'b0;
      frame_q <= 1'b0;
      din_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          clk_q   <= 1'b0;
          frame_q <= 1'b0;
          din_q   <= 1'b0;
          if (!empty) state <= LOAD;
        end
        LOAD: begin
          shreg   <= mem[rd_ptr[AW-1:0]];
          din_q   <= mem[rd_ptr[AW-1:0]][W-1];
          frame_q <= 1'b1;
          clk_q   <= 1'b0;
          div_cnt <= '0;
          bit_cnt <= '0;
          state   <= SHIFT;
        end
        SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            clk_q   <= ~clk_q;
            if (clk_q) begin
              frame_q <= 1'b0;
              shreg   <= shreg << 1;
              din_q   <= shreg[W-2];
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == BIT_LAST) begin
                din_q <= 1'b0;
                state <= empty ? IDLE : LOAD;
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ssp.ssp_clk   = clk_q;
  assign ssp.ssp_frame = frame_q;
  assign ssp.ssp_din   = din_q;

endmodule
